cache_port_arbiter: RTL and testbench

- Shares one port of the dual-port `cache_memory` among NUM_REQ requesters, e.g. an L1 core-side pipeline, a snoop/coherence engine and a fill unit.
- Arbitrates read, write and invalidate commands round-robin, issues them to the cache port through registers, and returns hit/way/data/coherence results tagged with the requester ID.
- Throughput: one command per cycle, fully pipelined, with an optional lock for back-to-back atomic sequences.

---
 rtl/cache_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_cache_port_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin arbiter sharing one cache_memory port among
// NUM_REQ requesters. Command registered to the port one cycle after the grant,
// response returned the cycle after that, tagged with the requester ID.
module cache_port_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ID_BITS        = 1,
  parameter int INDEX_BITS     = 6,
  parameter int TAG_BITS       = 20,
  parameter int COHERENCE_BITS = 2,
  parameter int STATUS_BITS    = 2,
  parameter int SBITS          = 4,
  parameter int BLOCK_WIDTH    = 128,
  parameter int WAY_BITS       = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_lock,
  input  logic [2*NUM_REQ-1:0]            req_op,
  input  logic [INDEX_BITS*NUM_REQ-1:0]   req_index,
  input  logic [TAG_BITS*NUM_REQ-1:0]     req_tag,
  input  logic [SBITS*NUM_REQ-1:0]        req_meta,
  input  logic [BLOCK_WIDTH*NUM_REQ-1:0]  req_data,
  input  logic [WAY_BITS*NUM_REQ-1:0]     req_way,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            resp_valid,
  output logic [ID_BITS-1:0]              resp_id,
  output logic [1:0]                      resp_op,
  output logic [BLOCK_WIDTH-1:0]          resp_data,
  output logic                            resp_hit,
  output logic [WAY_BITS-1:0]             resp_way,
  output logic [COHERENCE_BITS-1:0]       resp_coh,
  output logic [STATUS_BITS-1:0]          resp_status,
  output logic                            read,
  output logic                            write,
  output logic                            invalidate,
  output logic [INDEX_BITS-1:0]           index,
  output logic [TAG_BITS-1:0]             tag,
  output logic [SBITS-1:0]                meta_data,
  output logic [BLOCK_WIDTH-1:0]          data_in,
  output logic [WAY_BITS-1:0]             way_select,
  input  logic [BLOCK_WIDTH-1:0]          data_out,
  input  logic [WAY_BITS-1:0]             matched_way,
  input  logic [COHERENCE_BITS-1:0]       coh_bits,
  input  logic [STATUS_BITS-1:0]          status_bits,
  input  logic                            hit
);

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INVAL = 2'b10;
  localparam logic [ID_BITS:0] NUM_REQ_W = (ID_BITS+1)'(NUM_REQ);

  logic [ID_BITS-1:0]     rr_ptr;
  logic                   lock_valid;
  logic [ID_BITS-1:0]     lock_owner;

  logic [NUM_REQ-1:0]     grant;
  logic [ID_BITS-1:0]     grant_id;
  logic                   found;
  logic [ID_BITS:0]       cand_sum;
  logic [ID_BITS-1:0]     cand;
  logic                   handshake;

  logic [1:0]             sel_op;
  logic [INDEX_BITS-1:0]  sel_index;
  logic [TAG_BITS-1:0]    sel_tag;
  logic [SBITS-1:0]       sel_meta;
  logic [BLOCK_WIDTH-1:0] sel_data;
  logic [WAY_BITS-1:0]    sel_way;
  logic                   sel_is_read;

  logic                   s1_valid;
  logic [ID_BITS-1:0]     s1_id;
  logic [1:0]             s1_op;
  logic                   resp_is_read;

  // Grant selection: lock owner only, else first valid requester after rr_ptr.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    if (lock_valid) begin
      grant[lock_owner] = req_valid[lock_owner];
      grant_id          = lock_owner;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand_sum = {1'b0, rr_ptr} + (ID_BITS+1)'(k);
        if (cand_sum >= NUM_REQ_W) cand_sum = cand_sum - NUM_REQ_W;
        cand = cand_sum[ID_BITS-1:0];
        if (!found && req_valid[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_id    = cand;
        end
      end
    end
    // Reset is asynchronous, so the combinational grant must also drop at once.
    if (reset) grant = '0;
  end

  assign req_ready = grant;
  assign handshake = |grant;

  // Field mux from the single granted requester.
  always_comb begin
    sel_op    = '0;
    sel_index = '0;
    sel_tag   = '0;
    sel_meta  = '0;
    sel_data  = '0;
    sel_way   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op    = req_op[2*i +: 2];
        sel_index = req_index[INDEX_BITS*i +: INDEX_BITS];
        sel_tag   = req_tag[TAG_BITS*i +: TAG_BITS];
        sel_meta  = req_meta[SBITS*i +: SBITS];
        sel_data  = req_data[BLOCK_WIDTH*i +: BLOCK_WIDTH];
        sel_way   = req_way[WAY_BITS*i +: WAY_BITS];
      end
    end
  end

  // Reserved op 11 is issued to the cache as a read.
  assign sel_is_read = (sel_op != OP_WRITE) && (sel_op != OP_INVAL);

  // Round-robin pointer and lock ownership advance only on a handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      rr_ptr     <= ID_BITS'(NUM_REQ - 1);
      lock_valid <= 1'b0;
      lock_owner <= '0;
    end else if (handshake) begin
      rr_ptr     <= grant_id;
      lock_valid <= req_lock[grant_id];
      lock_owner <= grant_id;
    end else if (lock_valid && !req_valid[lock_owner]) begin
      lock_valid <= 1'b0;
    end
  end

  // Stage 1: registered command on the cache port, all fields zero when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read       <= 1'b0;
      write      <= 1'b0;
      invalidate <= 1'b0;
      index      <= '0;
      tag        <= '0;
      meta_data  <= '0;
      data_in    <= '0;
      way_select <= '0;
      s1_valid   <= 1'b0;
      s1_id      <= '0;
      s1_op      <= '0;
    end else begin
      read       <= handshake && sel_is_read;
      write      <= handshake && (sel_op == OP_WRITE);
      invalidate <= handshake && (sel_op == OP_INVAL);
      index      <= sel_index;
      tag        <= sel_tag;
      meta_data  <= sel_meta;
      data_in    <= sel_data;
      way_select <= sel_way;
      s1_valid   <= handshake;
      s1_id      <= grant_id & {ID_BITS{handshake}};
      s1_op      <= sel_op;
    end
  end

  // Stage 2: response tag; the cache delivers its result in this same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_op      <= '0;
      resp_is_read <= 1'b0;
    end else begin
      resp_valid   <= s1_valid;
      resp_id      <= s1_id;
      resp_op      <= s1_op;
      resp_is_read <= read;
    end
  end

  // Cache results are only meaningful for reads; writes/invalidates report zeros.
  assign resp_data   = resp_is_read ? data_out    : '0;
  assign resp_hit    = resp_is_read & hit;
  assign resp_way    = resp_is_read ? matched_way : '0;
  assign resp_coh    = resp_is_read ? coh_bits    : '0;
  assign resp_status = resp_is_read ? status_bits : '0;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: drives directed and random traffic, emulates the cache
// (one-cycle read latency), and compares every cycle against a behavioural model.
module tb_cache_port_arbiter;

  localparam int NR = 2, IB = 1, XB = 6, TB = 20, CB = 2, STB = 2, SB = 4, BW = 128, WB = 2;
  localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_INV = 2'b10, OP_RSV = 2'b11;
  localparam logic [BW-1:0] PRE_LINE = 128'hA5A5A5A5_0BBBB000_DEADBEEF_12345678;
  localparam logic [BW-1:0] W3_LINE  = 128'h11555555_99999999_33777777_00001000;

  logic              clock;
  logic              reset;
  logic [NR-1:0]     req_valid, req_lock, req_ready;
  logic [2*NR-1:0]   req_op;
  logic [XB*NR-1:0]  req_index;
  logic [TB*NR-1:0]  req_tag;
  logic [SB*NR-1:0]  req_meta;
  logic [BW*NR-1:0]  req_data;
  logic [WB*NR-1:0]  req_way;
  logic              resp_valid, resp_hit;
  logic [IB-1:0]     resp_id;
  logic [1:0]        resp_op;
  logic [BW-1:0]     resp_data;
  logic [WB-1:0]     resp_way;
  logic [CB-1:0]     resp_coh;
  logic [STB-1:0]    resp_status;
  logic              read, write, invalidate;
  logic [XB-1:0]     index;
  logic [TB-1:0]     tag;
  logic [SB-1:0]     meta_data;
  logic [BW-1:0]     data_in;
  logic [WB-1:0]     way_select;
  logic [BW-1:0]     data_out;
  logic [WB-1:0]     matched_way;
  logic [CB-1:0]     coh_bits;
  logic [STB-1:0]    status_bits;
  logic              hit;

  int checks = 0;
  int failures = 0;

  cache_port_arbiter #(
    .NUM_REQ(NR), .ID_BITS(IB), .INDEX_BITS(XB), .TAG_BITS(TB), .COHERENCE_BITS(CB),
    .STATUS_BITS(STB), .SBITS(SB), .BLOCK_WIDTH(BW), .WAY_BITS(WB)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_lock(req_lock), .req_op(req_op), .req_index(req_index),
    .req_tag(req_tag), .req_meta(req_meta), .req_data(req_data), .req_way(req_way),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_op(resp_op), .resp_data(resp_data),
    .resp_hit(resp_hit), .resp_way(resp_way), .resp_coh(resp_coh), .resp_status(resp_status),
    .read(read), .write(write), .invalidate(invalidate), .index(index), .tag(tag),
    .meta_data(meta_data), .data_in(data_in), .way_select(way_select),
    .data_out(data_out), .matched_way(matched_way), .coh_bits(coh_bits),
    .status_bits(status_bits), .hit(hit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cache line; meta_data is {status, coherence}, status[1] is the valid bit.
  typedef struct {
    logic [TB-1:0]  tag;
    logic [CB-1:0]  coh;
    logic [STB-1:0] st;
    logic [BW-1:0]  data;
  } line_t;

  typedef struct {
    logic           hit;
    logic [WB-1:0]  way;
    logic [CB-1:0]  coh;
    logic [STB-1:0] st;
    logic [BW-1:0]  data;
  } res_t;

  typedef struct {
    bit             v;
    int             id;
    logic [1:0]     op;
    logic [XB-1:0]  ix;
    logic [TB-1:0]  tg;
    logic [SB-1:0]  mt;
    logic [BW-1:0]  d;
    logic [WB-1:0]  w;
    res_t           res;
  } cmd_t;

  // mem[0] is the reference image, mem[1] the contents of the emulated cache.
  line_t mem [2][64][4];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cache behaviour: read looks up tag, miss reports first invalid way (else 0).
  function automatic res_t cache_op(input int m, input logic [1:0] op, input logic [XB-1:0] ix,
                                    input logic [TB-1:0] tg, input logic [SB-1:0] mt,
                                    input logic [BW-1:0] d, input logic [WB-1:0] w);
    res_t r;
    int rep;
    r.hit = 1'b0; r.way = '0; r.coh = '0; r.st = '0; r.data = '0;
    rep = -1;
    if (op == OP_WR) begin
      mem[m][ix][w].tag  = tg;
      mem[m][ix][w].coh  = mt[CB-1:0];
      mem[m][ix][w].st   = mt[SB-1:CB];
      mem[m][ix][w].data = d;
    end else if (op == OP_INV) begin
      mem[m][ix][w].st = '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (!r.hit && mem[m][ix][k].st[1] && mem[m][ix][k].tag == tg) begin
          r.hit  = 1'b1;
          r.way  = WB'(k);
          r.coh  = mem[m][ix][k].coh;
          r.st   = mem[m][ix][k].st;
          r.data = mem[m][ix][k].data;
        end
      end
      if (!r.hit) begin
        for (int k = 0; k < 4; k++) if (rep < 0 && !mem[m][ix][k].st[1]) rep = k;
        r.way = (rep < 0) ? '0 : WB'(rep);
      end
    end
    return r;
  endfunction

  // Cache emulator: results appear the cycle after the command; junk otherwise.
  res_t emu_r;
  always @(posedge clock) begin
    emu_r = cache_op(1, OP_RD, index, tag, '0, '0, '0);
    if (!read) begin
      if (write)      emu_r = cache_op(1, OP_WR,  index, tag, meta_data, data_in, way_select);
      if (invalidate) emu_r = cache_op(1, OP_INV, index, tag, meta_data, data_in, way_select);
      emu_r.hit  = 1'($urandom);
      emu_r.way  = WB'($urandom);
      emu_r.coh  = CB'($urandom);
      emu_r.st   = STB'($urandom);
      emu_r.data = {$urandom, $urandom, $urandom, $urandom};
    end
    data_out    <= emu_r.data;
    hit         <= emu_r.hit;
    matched_way <= emu_r.way;
    coh_bits    <= emu_r.coh;
    status_bits <= emu_r.st;
  end

  // Reference model: last winner, lock owner, and the two in-flight commands.
  int          m_last, m_owner, mon_g, mon_c;
  bit          m_lock;
  cmd_t        p1, p2;
  logic [NR-1:0] mon_exp;

  always @(negedge clock) begin
    if (reset) begin
      check("rst_ready", 256'(req_ready), 256'(0));
      check("rst_port", 256'({read, write, invalidate, index, tag, meta_data, way_select}), 256'(0));
      check("rst_wdata", 256'(data_in), 256'(0));
      check("rst_resp", 256'({resp_valid, resp_id, resp_op, resp_hit, resp_way, resp_coh, resp_status}), 256'(0));
      check("rst_rdata", 256'(resp_data), 256'(0));
      m_last = NR - 1; m_owner = 0; m_lock = 0;
      p1.v = 0; p2.v = 0;
    end else begin
      mon_g = -1;
      if (m_lock) begin
        if (req_valid[m_owner]) mon_g = m_owner;
      end else begin
        for (int k = 1; k <= NR; k++) begin
          mon_c = (m_last + k) % NR;
          if (mon_g < 0 && req_valid[mon_c]) mon_g = mon_c;
        end
      end
      mon_exp = '0;
      if (mon_g >= 0) mon_exp[mon_g] = 1'b1;
      check("grant", 256'(req_ready), 256'(mon_exp));

      check("port_cmd", 256'({read, write, invalidate}),
            p1.v ? 256'({(p1.op == OP_RD) || (p1.op == OP_RSV), p1.op == OP_WR, p1.op == OP_INV}) : 256'(0));
      check("port_fields", 256'({index, tag, meta_data, way_select}),
            p1.v ? 256'({p1.ix, p1.tg, p1.mt, p1.w}) : 256'(0));
      check("port_wdata", 256'(data_in), p1.v ? 256'(p1.d) : 256'(0));

      check("resp_valid", 256'(resp_valid), 256'(p2.v));
      if (p2.v) begin
        check("resp_id_op", 256'({resp_id, resp_op}), 256'({IB'(p2.id), p2.op}));
        check("resp_info", 256'({resp_hit, resp_way, resp_coh, resp_status}),
              256'({p2.res.hit, p2.res.way, p2.res.coh, p2.res.st}));
        check("resp_data", 256'(resp_data), 256'(p2.res.data));
      end

      p2   = p1;
      p1.v = 0;
      if (mon_g >= 0) begin
        p1.v   = 1;
        p1.id  = mon_g;
        p1.op  = req_op[2*mon_g +: 2];
        p1.ix  = req_index[XB*mon_g +: XB];
        p1.tg  = req_tag[TB*mon_g +: TB];
        p1.mt  = req_meta[SB*mon_g +: SB];
        p1.d   = req_data[BW*mon_g +: BW];
        p1.w   = req_way[WB*mon_g +: WB];
        p1.res = cache_op(0, p1.op, p1.ix, p1.tg, p1.mt, p1.d, p1.w);
        m_last  = mon_g;
        m_lock  = req_lock[mon_g];
        m_owner = mon_g;
      end else if (m_lock && !req_valid[m_owner]) begin
        m_lock = 0;
      end
    end
  end

  task automatic set_req(input int i, input bit v, input bit lk, input logic [1:0] op,
                         input logic [XB-1:0] ix, input logic [TB-1:0] tg, input logic [SB-1:0] mt,
                         input logic [BW-1:0] d, input logic [WB-1:0] w);
    req_valid[i] = v;
    req_lock[i]  = lk;
    req_op[2*i +: 2]      = op;
    req_index[XB*i +: XB] = ix;
    req_tag[TB*i +: TB]   = tg;
    req_meta[SB*i +: SB]  = mt;
    req_data[BW*i +: BW]  = d;
    req_way[WB*i +: WB]   = w;
  endtask

  task automatic idle(input int i);
    req_valid[i] = 1'b0;
    req_lock[i]  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  logic [TB-1:0] tag_pool [4];

  initial begin
    reset = 1'b1;
    req_valid = '0; req_lock = '0; req_op = '0; req_index = '0;
    req_tag = '0; req_meta = '0; req_data = '0; req_way = '0;
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 64; x++)
        for (int w = 0; w < 4; w++) begin
          mem[m][x][w].tag = '0; mem[m][x][w].coh = '0;
          mem[m][x][w].st = '0;  mem[m][x][w].data = '0;
        end
    for (int m = 0; m < 2; m++) begin
      mem[m][0][1].tag = 20'h2BBBB; mem[m][0][1].coh = 2'b01;
      mem[m][0][1].st = 2'b10;      mem[m][0][1].data = PRE_LINE;
      mem[m][0][0].tag = 20'h01234; mem[m][0][0].coh = 2'b00;
      mem[m][0][0].st = 2'b10;      mem[m][0][0].data = 128'h77;
    end
    tag_pool[0] = 20'h2BBBB; tag_pool[1] = 20'h2CCCC;
    tag_pool[2] = 20'h10000; tag_pool[3] = 20'h00001;
    tick(); tick();
    reset = 1'b0;

    // Preloaded hit from requester 0.
    set_req(0, 1, 0, OP_RD, 6'd0, 20'h2BBBB, '0, '0, '0);
    neg(); check("t1_ready", 256'(req_ready), 256'(2'b01));
    tick(); idle(0);
    neg(); check("t1_port", 256'({read, write, invalidate, index, tag}), 256'({3'b100, 6'd0, 20'h2BBBB}));
    tick();
    neg(); check("t1_resp", 256'({resp_valid, resp_id, resp_hit, resp_way}), 256'({1'b1, 1'b0, 1'b1, 2'd1}));
    check("t1_data", 256'(resp_data), 256'(PRE_LINE));
    tick();

    // Two persistent readers alternate after reset.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        set_req(0, 1, 0, OP_RD, 6'd1, 20'h10000, '0, '0, '0);
        set_req(1, 1, 0, OP_RD, 6'd1, 20'h00001, '0, '0, '0);
      end else begin
        idle(0); idle(1);
      end
      neg();
      if (k < 4) check("t2_ready", 256'(req_ready), (k % 2 == 0) ? 256'(2'b01) : 256'(2'b10));
      if (k >= 2) check("t2_resp", 256'({resp_valid, resp_id}), 256'({1'b1, IB'(k % 2)}));
      tick();
    end

    // Write then read of the same line on back-to-back cycles.
    set_req(0, 1, 0, OP_WR, 6'd0, 20'h2CCCC, 4'b1011, W3_LINE, 2'd2);
    neg(); check("t3_ready_w", 256'(req_ready), 256'(2'b01));
    tick(); idle(0);
    set_req(1, 1, 0, OP_RD, 6'd0, 20'h2CCCC, '0, '0, '0);
    neg(); check("t3_ready_r", 256'(req_ready), 256'(2'b10));
    check("t3_port_w", 256'({read, write, invalidate, way_select, data_in}), 256'({3'b010, 2'd2, W3_LINE}));
    tick(); idle(1);
    neg(); check("t3_resp_w", 256'({resp_valid, resp_id, resp_op, resp_hit}), 256'({1'b1, 1'b0, OP_WR, 1'b0}));
    tick();
    neg(); check("t3_resp_r", 256'({resp_id, resp_hit, resp_way, resp_coh, resp_status}),
                 256'({1'b1, 1'b1, 2'd2, 2'b11, 2'b10}));
    check("t3_data", 256'(resp_data), 256'(W3_LINE));
    tick();

    // Invalidate way1 then miss; replacement is the freshly invalid way1.
    set_req(0, 1, 0, OP_INV, 6'd0, 20'h2BBBB, '0, '0, 2'd1);
    neg(); check("t4_ready_i", 256'(req_ready), 256'(2'b01));
    tick(); idle(0);
    set_req(1, 1, 0, OP_RD, 6'd0, 20'h2BBBB, '0, '0, '0);
    neg(); tick(); idle(1);
    neg(); check("t4_resp_i", 256'({resp_valid, resp_op, resp_hit}), 256'({1'b1, OP_INV, 1'b0}));
    tick();
    neg(); check("t4_resp_r", 256'({resp_valid, resp_hit, resp_way}), 256'({1'b1, 1'b0, 2'd1}));
    tick();

    // Locked pair from requester 1 while requester 0 keeps asking.
    set_req(0, 1, 0, OP_RD, 6'd2, 20'h10000, '0, '0, '0);
    neg(); check("t5_pre", 256'(req_ready), 256'(2'b01));
    tick();
    set_req(1, 1, 1, OP_RD, 6'd3, 20'h10000, '0, '0, '0);
    neg(); check("t5_lock_rd", 256'(req_ready), 256'(2'b10));
    tick();
    set_req(1, 1, 0, OP_WR, 6'd3, 20'h10000, 4'b1001, 128'hCAFE, 2'd3);
    neg(); check("t5_lock_wr", 256'(req_ready), 256'(2'b10));
    tick(); idle(1);
    neg(); check("t5_release", 256'(req_ready), 256'(2'b01));
    tick(); idle(0); tick(); tick();

    // Reset right after a read handshake drops that read entirely.
    set_req(0, 1, 0, OP_RSV, 6'd0, 20'h2CCCC, '0, '0, '0);
    neg(); check("t6_ready", 256'(req_ready), 256'(2'b01));
    tick();
    reset = 1'b1;
    set_req(0, 1, 0, OP_RD, 6'd1, 20'h10000, '0, '0, '0);
    set_req(1, 1, 0, OP_RD, 6'd1, 20'h00001, '0, '0, '0);
    neg(); check("t6_rst_out", 256'({req_ready, read, resp_valid}), 256'(0));
    tick(); tick();
    reset = 1'b0; idle(0); idle(1);
    for (int k = 0; k < 3; k++) begin
      neg(); check("t6_no_resp", 256'(resp_valid), 256'(0));
      tick();
    end
    set_req(0, 1, 0, OP_RD, 6'd1, 20'h10000, '0, '0, '0);
    set_req(1, 1, 0, OP_RD, 6'd1, 20'h00001, '0, '0, '0);
    neg(); check("t6_first", 256'(req_ready), 256'(2'b01));
    tick(); idle(0); idle(1); tick(); tick();

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 9) < 7)
          set_req(i, 1, $urandom_range(0, 4) == 0, 2'($urandom), 6'($urandom_range(0, 3)),
                  tag_pool[$urandom_range(0, 3)], 4'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, 2'($urandom));
        else
          idle(i);
      end
      tick();
    end
    idle(0); idle(1);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
